// File: rtl/matrix_coeff_streamer.sv
// Double-buffered 3x3 coefficient bank streamed as 33-bit maybe-words (valid + data), row-major, with programmable idle gaps.
// Optional: define MATRIX_COEFF_STREAMER_REPEAT_EN to restream the active bank continuously after each frame.
module matrix_coeff_streamer #(
    parameter int unsigned DW      = 32,
    parameter int unsigned N_WORDS = 9,
    parameter int unsigned GAP_W   = 8
) (
    input  logic             system1000,
    input  logic             system1000_rstn,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic             commit,
    input  logic [GAP_W-1:0] gap,
    output logic [DW:0]      stream_out,
    output logic [3:0]       stream_idx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic               last_q, last_d;
    logic               load;
    logic               adv;

    logic [DW-1:0]      shadow_q   [N_WORDS];
    logic [DW-1:0]      shadow_nxt [N_WORDS];
    logic [DW-1:0]      active_q   [N_WORDS];

    logic [DW:0]        stream_out_q, stream_out_d;
    logic [IDX_W-1:0]   stream_idx_q, stream_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Shadow bank with this cycle's write merged, so a same-cycle commit picks it up.
    always_comb begin
        shadow_nxt = shadow_q;
        if (wr_en && (wr_addr < IDX_W'(N_WORDS))) begin
            shadow_nxt[wr_addr] = wr_data;
        end
    end

    // Coefficient banks.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int i = 0; i < int'(N_WORDS); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_nxt;
            if (load) begin
                active_q <= shadow_nxt;
            end
        end
    end

    // State and sequencing registers.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            last_q    <= last_d;
        end
    end

    // Next-state logic; adv marks the end of the current word's slot.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        last_d    = 1'b0;
        load      = 1'b0;
        adv       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (commit || pending_q) begin
                    load      = 1'b1;
                    idx_d     = '0;
                    pending_d = 1'b0;
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (commit) begin
                    pending_d = 1'b1;
                end
                cnt_d = gap;
                if (gap != '0) begin
                    state_d = ST_GAP;
                end else begin
                    adv = 1'b1;
                end
            end
            ST_GAP: begin
                if (commit) begin
                    pending_d = 1'b1;
                end
                cnt_d = cnt_q - GAP_W'(1);
                if (cnt_q == GAP_W'(1)) begin
                    adv = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (adv) begin
            if (idx_q == LAST_IDX) begin
                last_d = 1'b1;
                idx_d  = '0;
`ifdef MATRIX_COEFF_STREAMER_REPEAT_EN
                state_d = ST_EMIT;
                if (pending_d) begin
                    load      = 1'b1;
                    pending_d = 1'b0;
                end
`else
                state_d = ST_IDLE;
`endif
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = ST_EMIT;
            end
        end
    end

    // Output decode, registered one cycle later.
    always_comb begin
        stream_out_d = '0;
        stream_idx_d = '0;
        busy_d       = 1'b0;
        done_d       = last_q;
        case (state_q)
            ST_EMIT: begin
                stream_out_d = {1'b1, active_q[idx_q]};
                stream_idx_d = idx_q;
                busy_d       = 1'b1;
            end
            ST_GAP: begin
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            stream_out_q <= '0;
            stream_idx_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            stream_out_q <= stream_out_d;
            stream_idx_q <= stream_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign stream_out = stream_out_q;
    assign stream_idx = stream_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_matrix_coeff_streamer.sv
// Scoreboard bench for matrix_coeff_streamer (default single-shot build).
module tb_matrix_coeff_streamer;

    localparam int DW = 32;
    localparam int NW = 9;

    logic          clk;
    logic          rstn;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          commit;
    logic [7:0]    gap;
    logic [DW:0]   stream_out;
    logic [3:0]    stream_idx;
    logic          busy;
    logic          done;

    matrix_coeff_streamer dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .commit          (commit),
        .gap             (gap),
        .stream_out      (stream_out),
        .stream_idx      (stream_idx),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [35:0]   exp_q [$];
    logic [DW-1:0] m_shadow [NW];

    int cyc      = 0;
    int prev_cyc = 0;
    int last_cyc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int addr, input logic [DW-1:0] data, input bit with_commit);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_data = data;
        commit  = with_commit;
        if (addr < NW) m_shadow[addr] = data;
        tick();
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    task automatic commit_pulse();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < NW; i++) exp_q.push_back({4'(i), m_shadow[i]});
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) tick();
        check_eq("done_seen", 64'(done_cnt), 64'(target));
    endtask

    // Output monitor: pops the scoreboard on every valid word and checks framing.
    always @(negedge clk) begin
        if (rstn) begin
            cyc++;
            if (busy) busy_cnt++;
            if (stream_out[DW]) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexp_valid", 64'(stream_out), 64'(0));
                end else begin
                    check_eq("word", 64'({stream_idx, stream_out[DW-1:0]}), 64'(exp_q.pop_front()));
                end
                if (stream_idx != 4'd0) check_eq("gap_spacing", 64'(cyc - prev_cyc), 64'(1 + int'(gap)));
                prev_cyc = cyc;
                if (stream_idx == 4'(NW - 1)) last_cyc = cyc;
            end else begin
                check_eq("idle_zero", 64'({stream_idx, stream_out}), 64'(0));
            end
            if (done) begin
                done_cnt++;
                check_eq("done_pos", 64'(cyc - last_cyc), 64'(1 + int'(gap)));
            end
        end
    end

    initial begin
        int base_done;
        bit found;
        rstn    = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        commit  = 1'b0;
        gap     = '0;
        for (int i = 0; i < NW; i++) m_shadow[i] = '0;
        #12;
        check_eq("rst_out", 64'({stream_out, stream_idx, busy, done}), 64'(0));
        tick();
        rstn = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("idle_busy_done", 64'({busy, done}), 64'(0));
        end

        // gap=0 frame; word 8 written together with the commit.
        for (int i = 0; i < NW - 1; i++) write_word(i, DW'(32'h10 + i), 1'b0);
        busy_cnt = 0;
        push_frame();
        m_shadow[NW-1] = DW'(32'h18);
        exp_q[NW-1] = {4'(NW - 1), DW'(32'h18)};
        write_word(NW - 1, DW'(32'h18), 1'b1);
        check_eq("lat_pre", 64'({stream_out[DW], busy}), 64'(0));
        tick();
        check_eq("lat_first", 64'({stream_out[DW], stream_idx, busy}), 64'({1'b1, 4'd0, 1'b1}));
        wait_done(1, 40);
        check_eq("busy_len_g0", 64'(busy_cnt), 64'(NW));
        check_eq("q_empty_g0", 64'(exp_q.size()), 64'(0));

        // gap=2 frame.
        gap = 8'd2;
        tick();
        busy_cnt = 0;
        push_frame();
        commit_pulse();
        wait_done(2, 80);
        check_eq("busy_len_g2", 64'(busy_cnt), 64'(NW * 3));
        check_eq("q_empty_g2", 64'(exp_q.size()), 64'(0));

        // gap=1 frame with a rewrite and two commits while busy.
        gap = 8'd1;
        tick();
        busy_cnt = 0;
        push_frame();
        commit_pulse();
        for (int i = 0; i < 4; i++) tick();
        write_word(4, DW'(32'hDEAD), 1'b0);
        push_frame();
        commit_pulse();
        tick();
        commit_pulse();
        wait_done(3, 60);
        wait_done(4, 60);
        check_eq("busy_len_pend", 64'(busy_cnt), 64'(NW * 4));
        for (int i = 0; i < 40; i++) tick();
        check_eq("no_third_frame", 64'({done_cnt, 31'(0), busy}), 64'({4, 31'(0), 1'b0}));
        check_eq("q_empty_pend", 64'(exp_q.size()), 64'(0));

        // Out-of-range write is ignored.
        gap = 8'd0;
        write_word(9, DW'(32'hFFFF_FFFF), 1'b0);
        push_frame();
        commit_pulse();
        wait_done(5, 40);
        check_eq("q_empty_oob", 64'(exp_q.size()), 64'(0));

        // Mid-frame reset at idx 5.
        gap = 8'd1;
        tick();
        push_frame();
        commit_pulse();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (stream_out[DW] && stream_idx == 4'd5) found = 1'b1;
        end
        check_eq("reached_idx5", 64'(found), 64'(1));
        rstn = 1'b0;
        #1;
        check_eq("rst_mid_out", 64'({stream_out, stream_idx, busy, done}), 64'(0));
        exp_q.delete();
        for (int i = 0; i < NW; i++) m_shadow[i] = '0;
        base_done = done_cnt;
        tick();
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_eq("no_done_after_rst", 64'(done_cnt), 64'(base_done));
        push_frame();
        commit_pulse();
        wait_done(base_done + 1, 60);
        check_eq("q_empty_rst", 64'(exp_q.size()), 64'(0));

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/matrix_coeff_streamer.md
Name: matrix_coeff_streamer

Overview:
- Producer end of the 33-bit maybe-word stream used by the matrix-multiply core: bit 32 = valid, bits 31:0 = data.
- Holds a double-buffered 3x3 coefficient bank (9 words) written from the CPU register bus.
- On commit, emits the 9 words in row-major order as valid maybe-words, separated by a programmable number of idle cycles.
- Downstream hold-last-valid registers therefore see each coefficient exactly once per frame.

Parameters:
- DW, 32, data word width; stream word width is DW+1.
- N_WORDS, 9, words per frame (3x3 matrix).
- GAP_W, 8, width of the idle-gap count input.

Ports:
- system1000  in  1  clock
- system1000_rstn  in  1  asynchronous reset, active low
- wr_en  in  1  shadow-bank write strobe
- wr_addr  in  4  shadow word index, 0..N_WORDS-1
- wr_data  in  DW  shadow word data
- commit  in  1  single-cycle pulse: copy shadow to active bank and start a frame
- gap  in  GAP_W  idle cycles inserted after each valid word
- stream_out  out  DW+1  maybe-word; [DW] = valid, [DW-1:0] = data
- stream_idx  out  4  index of the word on stream_out; 0 when not valid
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last word's gap completes

Behaviour:
- Reset (async, low): shadow and active banks cleared to 0, state IDLE, stream_out=0, stream_idx=0, busy=0, done=0, pending=0.
- All outputs are registered. A reset asserted mid-frame aborts the frame immediately; stream_out returns to 0 and no done pulse is produced.
- Shadow writes: when wr_en=1 and wr_addr<N_WORDS, the shadow word is written at the clock edge. wr_addr>=N_WORDS is ignored. Writes are allowed in any state and never disturb the active bank.
- States: IDLE, EMIT, GAP.
- IDLE:
  - If commit or pending is set, the shadow bank is copied to the active bank, idx=0, pending is cleared and the state moves to EMIT.
  - A write and a commit in the same cycle: the new write is included in the copy (bypass).
- EMIT:
  - Drives stream_out={1,active[idx]}, stream_idx=idx, busy=1 for exactly one cycle.
  - The gap value is sampled into the gap counter at this point.
  - Next state is GAP if the sampled gap>0; otherwise the next word follows directly (back-to-back valid words).
- GAP:
  - stream_out={0, zeros}, stream_idx=0, busy=1.
  - The counter decrements each cycle; the wait ends after exactly the sampled gap cycles.
- After word N_WORDS-1 and its gap: done=1 for one cycle, then IDLE (busy=0).
  - With gap=0 the last word is followed directly by the done cycle.
- Latency: the first valid word appears 2 cycles after the commit edge (1 cycle to copy, 1 cycle for the output register).
- Frame length: N_WORDS*(1+gap) cycles of busy.
- A commit while busy sets pending; it does not restart the current frame.
  - The pending frame starts from IDLE on the cycle after done.
  - Multiple commits while busy collapse into one pending frame.
- gap changes mid-frame take effect from the next EMIT.
- Data is passed through unmodified; no arithmetic and no sign handling.

Optional Feature:
- Macro: MATRIX_COEFF_STREAMER_REPEAT_EN.
- Defined:
  - After done, the block re-enters EMIT with idx=0 and restreams the active bank continuously. done still pulses once per frame.
  - A commit takes effect only at the frame boundary: the shadow is copied at the wrap point and pending is cleared.
  - busy stays 1 until reset.
- Undefined: single-shot behaviour as above. The pending/commit logic is unchanged.

Test Plan:
- Reset, then idle 10 cycles -> stream_out=0, busy=0, done=0 throughout.
- Write words 0..8 = 0x10..0x18, gap=0, commit -> 9 consecutive valid words 0x10..0x18 with idx 0..8, starting 2 cycles after commit; done pulse on the following cycle; busy high for 9 cycles.
- Same data, gap=2 -> each valid word followed by 2 cycles of stream_out=0; busy high 27 cycles; done exactly once.
- During a gap=1 frame, rewrite word 4 = 0xDEAD and commit twice -> current frame still shows 0x14 at idx 4; a second frame starts after done with 0xDEAD at idx 4; no third frame.
- Write wr_addr=9 with 0xFFFF_FFFF, then commit -> frame contents unchanged from the previous shadow.
- Assert system1000_rstn low at idx 5 mid-frame -> outputs go to 0 immediately; after release, commit streams all zeros (banks cleared). With MATRIX_COEFF_STREAMER_REPEAT_EN: the frame repeats and done pulses every 9*(1+gap) cycles.
